// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for one systolic weight tile: weight preload, activation stream, drain with result tagging.
// Optional macro PE_SEQ_CTRL_PERF_EN adds busy-cycle and job counters.
module pe_array_seq_ctrl #(
    parameter int data_width         = 22,
    parameter int w_tile_column_size = 16,
    parameter int w_tile_row_size    = 16,
    parameter int vec_cnt_width      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [vec_cnt_width-1:0]           num_vec,
    output logic                               busy,
    output logic                               done,
    output logic                               w_en,
    output logic                               w_compute,
    output logic                               w_rd_en,
    output logic [$clog2(w_tile_row_size)-1:0] w_rd_addr,
    output logic                               act_rd_en,
    output logic [vec_cnt_width-1:0]           act_rd_addr,
    output logic                               act_zero,
    output logic                               res_valid,
    output logic [vec_cnt_width-1:0]           res_idx
`ifdef PE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]                        perf_busy_cycles,
    output logic [15:0]                        perf_jobs
`endif
);

    localparam int LAT  = w_tile_row_size + w_tile_column_size - 1;
    localparam int AW   = $clog2(w_tile_row_size);
    localparam int VW   = vec_cnt_width;
    localparam int LW   = $clog2(LAT + 1);
    localparam int RW   = $clog2(w_tile_row_size + 1);
    localparam int CW0  = (VW > RW) ? VW : RW;
    localparam int CW   = (CW0 > LW) ? CW0 : LW;

    if (data_width < 1) begin : g_dw_chk
        $error("data_width must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SETTLE,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   nv_q, nv_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            abort_take;
    logic            in_cd_q, in_cd_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            w_en_q, w_en_d;
    logic            w_compute_q, w_compute_d;
    logic            w_rd_en_q, w_rd_en_d;
    logic [AW-1:0]   w_rd_addr_q, w_rd_addr_d;
    logic            act_rd_en_q, act_rd_en_d;
    logic [VW-1:0]   act_rd_addr_q, act_rd_addr_d;
    logic            act_zero_q, act_zero_d;
    logic            res_valid_q, res_valid_d;
    logic [VW-1:0]   res_idx_q, res_idx_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nv_d       = nv_q;
        abort_take = abort && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD_W;
                    nv_d    = num_vec;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (cnt_q == CW'(w_tile_row_size - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                cnt_d   = '0;
                state_d = (nv_q != '0) ? COMPUTE : DONE;
            end
            COMPUTE: begin
                if (cnt_q == (CW'(nv_q) - CW'(1))) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_take) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // lat counts cycles since the first activation entered; results emerge once it reaches LAT
        in_cd_q = (state_q == COMPUTE) || (state_q == DRAIN);
        in_cd_d = (state_d == COMPUTE) || (state_d == DRAIN);
        lat_d   = '0;
        if (in_cd_d && in_cd_q) begin
            lat_d = (lat_q == LW'(LAT)) ? lat_q : lat_q + LW'(1);
        end

        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        w_en_d        = (state_d == LOAD_W);
        w_rd_en_d     = (state_d == LOAD_W);
        w_rd_addr_d   = (state_d == LOAD_W) ? cnt_d[AW-1:0] : '0;
        w_compute_d   = in_cd_d;
        act_rd_en_d   = (state_d == COMPUTE);
        act_rd_addr_d = (state_d == COMPUTE) ? cnt_d[VW-1:0] : '0;
        act_zero_d    = (state_d == DRAIN);
        res_valid_d   = in_cd_d && (lat_d == LW'(LAT));

        res_idx_d = res_idx_q;
        if (abort_take) begin
            res_idx_d = '0;
        end else if (res_valid_d) begin
            res_idx_d = res_valid_q ? res_idx_q + VW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            nv_q          <= '0;
            lat_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            w_en_q        <= 1'b0;
            w_compute_q   <= 1'b0;
            w_rd_en_q     <= 1'b0;
            w_rd_addr_q   <= '0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            act_zero_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nv_q          <= nv_d;
            lat_q         <= lat_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            w_en_q        <= w_en_d;
            w_compute_q   <= w_compute_d;
            w_rd_en_q     <= w_rd_en_d;
            w_rd_addr_q   <= w_rd_addr_d;
            act_rd_en_q   <= act_rd_en_d;
            act_rd_addr_q <= act_rd_addr_d;
            act_zero_q    <= act_zero_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign w_en        = w_en_q;
    assign w_compute   = w_compute_q;
    assign w_rd_en     = w_rd_en_q;
    assign w_rd_addr   = w_rd_addr_q;
    assign act_rd_en   = act_rd_en_q;
    assign act_rd_addr = act_rd_addr_q;
    assign act_zero    = act_zero_q;
    assign res_valid   = res_valid_q;
    assign res_idx     = res_idx_q;

`ifdef PE_SEQ_CTRL_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_jobs_q;

    // the cycle that accepts start is charged to the job along with every busy cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_q <= '0;
            perf_jobs_q <= '0;
        end else begin
            if ((busy_q || busy_d) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q) begin
                perf_jobs_q <= perf_jobs_q + 16'd1;
            end
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_jobs        = perf_jobs_q;
`else
    // performance counters are not built
`endif

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Bench for pe_array_seq_ctrl: timeline model for control outputs, queue scoreboard for results.
module tb_pe_array_seq_ctrl;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int VW   = 16;
    localparam int AW   = 4;
    localparam int LAT  = ROWS + COLS - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [VW-1:0] num_vec = '0;
    logic          busy, done, w_en, w_compute, w_rd_en, act_rd_en, act_zero, res_valid;
    logic [AW-1:0] w_rd_addr;
    logic [VW-1:0] act_rd_addr, res_idx;
`ifdef PE_SEQ_CTRL_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_jobs;
`endif

    pe_array_seq_ctrl #(
        .data_width(22), .w_tile_column_size(COLS), .w_tile_row_size(ROWS), .vec_cnt_width(VW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
        .busy(busy), .done(done), .w_en(w_en), .w_compute(w_compute), .w_rd_en(w_rd_en),
        .w_rd_addr(w_rd_addr), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .act_zero(act_zero), .res_valid(res_valid), .res_idx(res_idx)
`ifdef PE_SEQ_CTRL_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_jobs(perf_jobs)
`endif
    );

    typedef struct packed {
        logic          busy, done, w_en, w_rd_en, w_compute, act_rd_en, act_zero;
        logic [AW-1:0] w_rd_addr;
        logic [VW-1:0] act_rd_addr;
    } ctrl_t;

    typedef struct {
        int idx;
        int cyc;
    } res_t;

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        res_t e;
        if (res_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL res_unexpected: res_idx=%0d at cyc %0d, required no result", res_idx, cyc);
            end else begin
                e = sb.pop_front();
                if (res_idx !== VW'(e.idx) || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL res_seq: got idx %0d at cyc %0d, required idx %0d at cyc %0d",
                             res_idx, cyc, e.idx, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t exp_at(input int k, input int n);
        ctrl_t e;
        int    done_k;
        e      = '0;
        done_k = (n == 0) ? ROWS + 2 : ROWS + 2 + n + LAT;
        if (k >= 1 && k <= done_k) e.busy = 1'b1;
        if (k >= 1 && k <= ROWS) begin
            e.w_en      = 1'b1;
            e.w_rd_en   = 1'b1;
            e.w_rd_addr = AW'(k - 1);
        end
        if (n > 0 && k >= ROWS + 2 && k < ROWS + 2 + n) begin
            e.w_compute   = 1'b1;
            e.act_rd_en   = 1'b1;
            e.act_rd_addr = VW'(k - ROWS - 2);
        end
        if (n > 0 && k >= ROWS + 2 + n && k < done_k) begin
            e.w_compute = 1'b1;
            e.act_zero  = 1'b1;
        end
        if (k == done_k) e.done = 1'b1;
        return e;
    endfunction

    // start a job with n vectors; cut_k>0 aborts (or resets when by_rst) during cycle T+cut_k
    task automatic run_job(input int n, input int cut_k, input bit by_rst, input int kmax);
        ctrl_t e, a;
        int    t0, done_k;
        bit    after_cut;
        done_k  = (n == 0) ? ROWS + 2 : ROWS + 2 + n + LAT;
        num_vec = VW'(n);
        start   = 1'b1;
        tick();
        t0      = cyc;
        start   = 1'b0;
        num_vec = VW'($urandom);
        for (int j = 0; j < n; j++) sb.push_back('{idx: j, cyc: t0 + ROWS + 1 + LAT + j});
        for (int k = 1; k <= kmax; k++) begin
            after_cut = (cut_k > 0) && (k > cut_k);
            e = after_cut ? ctrl_t'('0) : exp_at(k, n);
            a = {busy, done, w_en, w_rd_en, w_compute, act_rd_en, act_zero, w_rd_addr, act_rd_addr};
            if (!after_cut) begin
                if (!e.w_rd_en)   a.w_rd_addr   = '0;
                if (!e.act_rd_en) a.act_rd_addr = '0;
            end
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL ctrl n=%0d k=%0d: got %h, required %h", n, k, a, e);
            end
            if (after_cut) begin
                tests++;
                if (res_valid !== 1'b0 || res_idx !== '0) begin
                    fails++;
                    $display("FAIL cut_res n=%0d k=%0d: got valid=%b idx=%0d, required 0/0",
                             n, k, res_valid, res_idx);
                end
            end else if (n > 0 && k >= done_k) begin
                tests++;
                if (res_valid !== 1'b0 || res_idx !== VW'(n - 1)) begin
                    fails++;
                    $display("FAIL res_hold n=%0d k=%0d: got valid=%b idx=%0d, required 0/%0d",
                             n, k, res_valid, res_idx, n - 1);
                end
            end
            if (cut_k > 0 && k == cut_k) begin
                if (by_rst) rst_n = 1'b0;
                else        abort = 1'b1;
            end
            if (cut_k > 0 && k == cut_k + 1) begin
                rst_n = 1'b1;
                abort = 1'b0;
                sb.delete();
            end
            tick();
        end
        if (cut_k == 0 && kmax >= done_k) begin
            tests++;
            if (sb.size() != 0) begin
                fails++;
                $display("FAIL res_missing n=%0d: got %0d results outstanding, required 0", n, sb.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        num_vec = 16'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({busy, done, w_en, w_compute, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
                 act_zero, res_valid, res_idx} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got busy=%b w_en=%b res_idx=%0d, required all 0",
                         i, busy, w_en, res_idx);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        run_job(5, 0, 1'b0, 60);
    endtask

    task automatic test_zero_vec();
        run_job(0, 0, 1'b0, 22);
    endtask

    task automatic test_abort();
        run_job(5, 20, 1'b0, 24);
        run_job(5, 0, 1'b0, 58);
    endtask

    task automatic test_abort_start_idle();
        abort   = 1'b1;
        start   = 1'b1;
        num_vec = 16'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (busy !== 1'b0 || w_en !== 1'b0) begin
                fails++;
                $display("FAIL abort_start_idle cycle %0d: got busy=%b w_en=%b, required 0/0", i, busy, w_en);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t0, nd, d0, d1;
        nd = 0; d0 = -1; d1 = -1;
        num_vec = 16'd1;
        start   = 1'b1;
        tick();
        t0 = cyc;
        for (int j = 0; j < 2; j++) sb.push_back('{idx: 0, cyc: t0 + 51 * j + ROWS + 1 + LAT});
        for (int c = 1; c <= 130; c++) begin
            if (done === 1'b1) begin
                if (nd == 0) d0 = c;
                else if (nd == 1) d1 = c;
                nd++;
            end
            num_vec = (c == 51) ? 16'd1 : VW'($urandom_range(2, 200));
            start   = (c <= 99);
            tick();
        end
        start = 1'b0;
        tests++;
        if (nd != 2 || d0 != ROWS + 2 + 1 + LAT || d1 - d0 != 51) begin
            fails++;
            $display("FAIL back_to_back: got %0d dones at %0d,%0d, required 2 at 50,101", nd, d0, d1);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_results: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_drain();
        run_job(5, 50, 1'b1, 56);
        run_job(3, 0, 1'b0, 56);
    endtask

`ifdef PE_SEQ_CTRL_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_job(5, 0, 1'b0, 57);
        run_job(0, 0, 1'b0, 22);
        tests++;
        if (perf_jobs !== 16'd2 || perf_busy_cycles !== 32'd74) begin
            fails++;
            $display("FAIL perf: got jobs=%0d busy=%0d, required 2/74", perf_jobs, perf_busy_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_zero_vec();
        test_abort();
        test_abort_start_idle();
        test_back_to_back();
        test_reset_drain();
`ifdef PE_SEQ_CTRL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
